decode_scoreboard: RTL and testbench

Parametrised register scoreboard for the decode stage of the MIPS pipeline, generalising fixed load-use stall detection to results of any latency from 0 to `MAX_LAT`.
- Tracks every in-flight register write with a per-register countdown.
- Detects RAW, WAW and writeback-port conflicts for the instruction presented in decode.
- Drives the decode stall and a saturating stall-cycle counter.
- Sits beside decode: decode supplies the instruction's source/destination addresses and result latency, and the scoreboard answers whether it may issue this cycle.

---
 rtl/decode_scoreboard_pkg.sv | 17 +
 rtl/decode_scoreboard_sb_counter.sv | 29 ++
 rtl/decode_scoreboard.sv | 91 +++++++++
 tb/tb_decode_scoreboard.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_scoreboard_pkg.sv
// Shared decode-stage constants: result latencies and scoreboard defaults.
package decode_scoreboard_pkg;

  // Result latencies seen by decode (cycles before a dependent may issue)
  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 1;
  localparam int LAT_MUL  = 3;

  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_MAX_LAT  = 4;

  // Counter width able to hold MAX_LAT+1 (the writeback-slot probe value)
  function automatic int lat_width(input int max_lat);
    return $clog2(max_lat + 2);
  endfunction

endpackage

// File: rtl/decode_scoreboard_sb_counter.sv
// One per-register countdown: loads the issue latency, then decrements to zero.
module decode_scoreboard_sb_counter #(
  parameter int LAT_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_hold,
  input  logic             i_load,
  input  logic [LAT_W-1:0] i_load_val,
  output logic [LAT_W-1:0] o_cnt
);

  logic [LAT_W-1:0] r_cnt;

  // Frozen while held; a fresh load wins over the decrement
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (!i_hold) begin
      if (i_load)
        r_cnt <= i_load_val;
      else if (r_cnt != '0)
        r_cnt <= r_cnt - LAT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/decode_scoreboard.sv
// Decode-stage register scoreboard: RAW / WAW / writeback-port stall detection
// for results of latency 0..MAX_LAT, plus a saturating stall-cycle counter.
module decode_scoreboard
  import decode_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int MAX_LAT  = DEF_MAX_LAT,
  parameter int LAT_W    = lat_width(MAX_LAT),
  parameter int PERF_W   = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_issue_valid,
  input  logic                i_hold,
  input  logic [ADDR_W-1:0]   i_src0_addr,
  input  logic [ADDR_W-1:0]   i_src1_addr,
  input  logic                i_src0_rd,
  input  logic                i_src1_rd,
  input  logic [ADDR_W-1:0]   i_dst_addr,
  input  logic                i_dst_we,
  input  logic [LAT_W-1:0]    i_issue_lat,
  output logic                o_stall,
  output logic                o_stall_raw,
  output logic                o_stall_waw,
  output logic                o_stall_wb,
  output logic                o_issue_fire,
  output logic [NUM_REGS-1:0] o_busy_vec,
  output logic [PERF_W-1:0]   o_stall_count
);

  logic [LAT_W-1:0]  w_cnt [NUM_REGS];
  logic [LAT_W-1:0]  w_lat_p1;
  logic              w_wb_hit;
  logic              w_load_en;
  logic [PERF_W-1:0] r_stall_count;

  // r0 is hardwired zero and never tracked
  assign w_cnt[0] = '0;

  // Only latency>0 writes to a real register occupy a slot
  assign w_load_en = o_issue_fire && i_dst_we && (i_dst_addr != '0) && (i_issue_lat != '0);

  genvar r;
  generate
    for (r = 1; r < NUM_REGS; r++) begin : g_cnt
      decode_scoreboard_sb_counter #(.LAT_W(LAT_W)) u_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_hold     (i_hold),
        .i_load     (w_load_en && (i_dst_addr == ADDR_W'(r))),
        .i_load_val (i_issue_lat),
        .o_cnt      (w_cnt[r])
      );
    end
  endgenerate

  // A pending result at cnt == lat+1 would share the writeback slot with this one
  assign w_lat_p1 = i_issue_lat + LAT_W'(1);

  // Busy vector and writeback-slot probe across all registers
  always_comb begin
    o_busy_vec = '0;
    w_wb_hit   = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      o_busy_vec[i] = (w_cnt[i] != '0);
      if (w_cnt[i] == w_lat_p1) w_wb_hit = 1'b1;
    end
  end

  // Hazard decode; the own-destination check uses the pre-issue counter
  always_comb begin
    o_stall_raw  = (i_src0_rd && (w_cnt[i_src0_addr] != '0)) ||
                   (i_src1_rd && (w_cnt[i_src1_addr] != '0));
    o_stall_waw  = i_dst_we && (i_dst_addr != '0) && (w_cnt[i_dst_addr] != '0);
    o_stall_wb   = i_dst_we && w_wb_hit;
    o_stall      = i_issue_valid && (o_stall_raw || o_stall_waw || o_stall_wb);
    o_issue_fire = i_issue_valid && !o_stall && !i_hold;
  end

  // Saturating count of un-held stalled cycles
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_stall_count <= '0;
    else if (o_stall && !i_hold && (r_stall_count != '1))
      r_stall_count <= r_stall_count + PERF_W'(1);
  end

  assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_decode_scoreboard.sv
// Self-checking bench: directed scenarios plus randomized traffic against an
// absolute-time reference model (each register remembers when it becomes free).
module tb_decode_scoreboard;
  localparam int NR = 32, AW = 5, ML = 4, LW = 3;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_issue_valid = 1'b0, i_hold = 1'b0;
  logic [AW-1:0] i_src0_addr = '0, i_src1_addr = '0, i_dst_addr = '0;
  logic          i_src0_rd = 1'b0, i_src1_rd = 1'b0, i_dst_we = 1'b0;
  logic [LW-1:0] i_issue_lat = '0;
  logic          o_stall, o_stall_raw, o_stall_waw, o_stall_wb, o_issue_fire;
  logic [NR-1:0] o_busy_vec;
  logic [31:0]   o_stall_count;
  logic          s_stall, s_raw, s_waw, s_wb, s_fire;
  logic [NR-1:0] s_busy;
  logic [3:0]    s_count;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  decode_scoreboard #(.NUM_REGS(NR), .ADDR_W(AW), .MAX_LAT(ML), .LAT_W(LW), .PERF_W(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_issue_valid(i_issue_valid), .i_hold(i_hold),
    .i_src0_addr(i_src0_addr), .i_src1_addr(i_src1_addr), .i_src0_rd(i_src0_rd),
    .i_src1_rd(i_src1_rd), .i_dst_addr(i_dst_addr), .i_dst_we(i_dst_we),
    .i_issue_lat(i_issue_lat), .o_stall(o_stall), .o_stall_raw(o_stall_raw),
    .o_stall_waw(o_stall_waw), .o_stall_wb(o_stall_wb), .o_issue_fire(o_issue_fire),
    .o_busy_vec(o_busy_vec), .o_stall_count(o_stall_count));

  // Narrow perf counter copy, driven by the same inputs, to observe saturation
  decode_scoreboard #(.NUM_REGS(NR), .ADDR_W(AW), .MAX_LAT(ML), .LAT_W(LW), .PERF_W(4)) dut_s (
    .i_clk(i_clk), .i_rst(i_rst), .i_issue_valid(i_issue_valid), .i_hold(i_hold),
    .i_src0_addr(i_src0_addr), .i_src1_addr(i_src1_addr), .i_src0_rd(i_src0_rd),
    .i_src1_rd(i_src1_rd), .i_dst_addr(i_dst_addr), .i_dst_we(i_dst_we),
    .i_issue_lat(i_issue_lat), .o_stall(s_stall), .o_stall_raw(s_raw),
    .o_stall_waw(s_waw), .o_stall_wb(s_wb), .o_issue_fire(s_fire),
    .o_busy_vec(s_busy), .o_stall_count(s_count));

  // Inputs change 1 time unit after the edge; outputs are checked 2 units later
  task automatic drive(input bit v, input bit h, input int s0, input bit r0,
                       input int s1, input bit r1, input int d, input bit we, input int lat);
    i_issue_valid = v; i_hold = h;
    i_src0_addr = AW'(s0); i_src0_rd = r0;
    i_src1_addr = AW'(s1); i_src1_rd = r1;
    i_dst_addr = AW'(d); i_dst_we = we; i_issue_lat = LW'(lat);
    #2;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1; idle(); tick(); tick(); i_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(); idle();
    checks++; if (o_busy_vec !== '0) begin errors++; $display("FAIL rst_busy got %h want 0", o_busy_vec); end
    checks++; if (o_stall_count !== 32'd0) begin errors++; $display("FAIL rst_count got %0d want 0", o_stall_count); end
    for (int k = 0; k < 8; k++) begin
      drive(1, 1, $urandom_range(0, 31), 1, $urandom_range(0, 31), 1, $urandom_range(0, 31), 1, $urandom_range(0, ML));
      checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL rst_nostall got %0b want 0", o_stall); end
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 8, 1, 1);
    checks++; if (o_issue_fire !== 1'b1) begin errors++; $display("FAIL lu_issue got %0b want 1", o_issue_fire); end
    tick();
    drive(1, 0, 8, 1, 0, 0, 0, 0, 0);
    checks++; if ({o_stall, o_stall_raw, o_issue_fire} !== 3'b110) begin errors++; $display("FAIL lu_t1 got %b want 110", {o_stall, o_stall_raw, o_issue_fire}); end
    tick();
    checks++; if ({o_stall, o_issue_fire} !== 2'b01) begin errors++; $display("FAIL lu_t2 got %b want 01", {o_stall, o_issue_fire}); end
    checks++; if (o_stall_count !== 32'd1) begin errors++; $display("FAIL lu_count got %0d want 1", o_stall_count); end
    tick();
  endtask

  task automatic test_mul();
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 9, 1, 3);
    tick();
    for (int t = 1; t <= 3; t++) begin
      drive(1, 0, 0, 0, 9, 1, 0, 0, 0);
      checks++; if ({o_stall, o_busy_vec[9]} !== 2'b11) begin errors++; $display("FAIL mul_t%0d got %b want 11", t, {o_stall, o_busy_vec[9]}); end
      tick();
    end
    checks++; if ({o_issue_fire, o_busy_vec[9]} !== 2'b10) begin errors++; $display("FAIL mul_t4 got %b want 10", {o_issue_fire, o_busy_vec[9]}); end
    checks++; if (o_stall_count !== 32'd3) begin errors++; $display("FAIL mul_count got %0d want 3", o_stall_count); end
    tick();
  endtask

  task automatic test_wb_collision();
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 9, 1, 3);   // cnt9 reads 3 next cycle, 2 the one after
    tick(); idle(); tick();
    drive(1, 0, 0, 0, 0, 0, 10, 1, 1);
    checks++; if ({o_stall, o_stall_wb, o_stall_raw, o_stall_waw} !== 4'b1100) begin errors++; $display("FAIL wb_hit got %b want 1100", {o_stall, o_stall_wb, o_stall_raw, o_stall_waw}); end
    tick();
    checks++; if (o_issue_fire !== 1'b1) begin errors++; $display("FAIL wb_fire got %0b want 1", o_issue_fire); end
    tick(); idle();
    checks++; if (o_busy_vec !== (32'd1 << 10)) begin errors++; $display("FAIL wb_busy got %h want %h", o_busy_vec, 32'd1 << 10); end
    tick();
  endtask

  task automatic test_waw_r0();
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 9, 1, 3);
    tick();
    drive(1, 0, 0, 0, 0, 0, 9, 1, 1);
    checks++; if ({o_stall, o_stall_waw, o_stall_wb} !== 3'b110) begin errors++; $display("FAIL waw got %b want 110", {o_stall, o_stall_waw, o_stall_wb}); end
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 1, 0, 1, 0, 1, 4);
      checks++; if ({o_stall, o_issue_fire, o_busy_vec} !== {2'b01, 32'd0}) begin errors++; $display("FAIL r0_%0d got %b/%b busy %h want 0/1 busy 0", k, o_stall, o_issue_fire, o_busy_vec); end
      tick();
    end
  endtask

  task automatic test_hold();
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 9, 1, 3);
    tick(); idle(); tick();             // cnt9 == 2
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 9, 1, 0, 0, 0, 0, 0);
      checks++; if ({o_stall, o_issue_fire, o_busy_vec[9]} !== 3'b101) begin errors++; $display("FAIL hold_%0d got %b want 101", k, {o_stall, o_issue_fire, o_busy_vec[9]}); end
      tick();
    end
    checks++; if (o_stall_count !== 32'd0) begin errors++; $display("FAIL hold_count got %0d want 0", o_stall_count); end
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 9, 1, 0, 0, 0, 0, 0);
      checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL rel_%0d got %0b want 1", k, o_stall); end
      tick();
    end
    drive(1, 0, 9, 1, 0, 0, 0, 0, 0);
    checks++; if ({o_issue_fire, o_stall_count} !== {1'b1, 32'd2}) begin errors++; $display("FAIL rel_free got %0b/%0d want 1/2", o_issue_fire, o_stall_count); end
    tick();
  endtask

  task automatic test_reset_sat();
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 8, 1, 1); tick();
    drive(1, 0, 8, 1, 0, 0, 0, 0, 0); tick();   // one stall counted
    drive(1, 0, 0, 0, 0, 0, 9, 1, 3); tick();
    drive(1, 0, 9, 1, 0, 0, 0, 0, 0);           // cnt9 == 3
    checks++; if ({o_stall, o_stall_count} !== {1'b1, 32'd1}) begin errors++; $display("FAIL pre_rst got %0b/%0d want 1/1", o_stall, o_stall_count); end
    i_rst = 1'b1; tick(); i_rst = 1'b0; #2;
    checks++; if ({o_busy_vec, o_stall_count, o_stall} !== {32'd0, 32'd0, 1'b0}) begin errors++; $display("FAIL mid_rst got busy %h cnt %0d stall %0b want 0/0/0", o_busy_vec, o_stall_count, o_stall); end
    tick();
    do_reset();
    for (int rep = 0; rep < 5; rep++) begin
      drive(1, 0, 0, 0, 0, 0, 9, 1, 4); tick();
      for (int k = 0; k < 4; k++) begin drive(1, 0, 9, 1, 0, 0, 0, 0, 0); tick(); end
    end
    idle();
    checks++; if (s_count !== 4'd15) begin errors++; $display("FAIL sat4 got %0d want 15", s_count); end
    checks++; if (o_stall_count !== 32'd20) begin errors++; $display("FAIL cnt32 got %0d want 20", o_stall_count); end
    tick();
  endtask

  // Reference: free_at[r] is the un-held cycle index at which r becomes readable
  task automatic test_random();
    int free_at [NR];
    int now, mcount, rem, lat, d, s0, s1;
    bit v, h, r0, r1, we, rs, e_raw, e_waw, e_wb, e_stall, e_fire;
    logic [NR-1:0] e_busy;
    do_reset();
    foreach (free_at[r]) free_at[r] = 0;
    now = 0; mcount = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      v = ($urandom_range(0, 9) != 0); h = ($urandom_range(0, 5) == 0);
      s0 = $urandom_range(0, 7); s1 = $urandom_range(0, 7); d = $urandom_range(0, 7);
      r0 = $urandom_range(0, 1); r1 = $urandom_range(0, 1); we = ($urandom_range(0, 3) != 0);
      lat = $urandom_range(0, ML); rs = ($urandom_range(0, 99) == 0);
      i_rst = rs;
      drive(v, h, s0, r0, s1, r1, d, we, lat);
      e_busy = '0; e_wb = 1'b0;
      for (int r = 1; r < NR; r++) begin
        rem = (free_at[r] > now) ? free_at[r] - now : 0;
        e_busy[r] = (rem != 0);
        if (we && rem == lat + 1) e_wb = 1'b1;
      end
      e_raw = (r0 && e_busy[s0]) || (r1 && e_busy[s1]);
      e_waw = we && d != 0 && e_busy[d];
      e_stall = v && (e_raw || e_waw || e_wb);
      e_fire = v && !e_stall && !h;
      checks++;
      if ({o_stall_raw, o_stall_waw, o_stall_wb, o_stall, o_issue_fire} !== {e_raw, e_waw, e_wb, e_stall, e_fire}
          || o_busy_vec !== e_busy || o_stall_count !== 32'(mcount)
          || s_count !== 4'((mcount > 15) ? 15 : mcount)) begin
        errors++;
        $display("FAIL rand_%0d got rwbsf=%b busy=%h cnt=%0d/%0d want %b busy=%h cnt=%0d", cyc,
                 {o_stall_raw, o_stall_waw, o_stall_wb, o_stall, o_issue_fire}, o_busy_vec, o_stall_count, s_count,
                 {e_raw, e_waw, e_wb, e_stall, e_fire}, e_busy, mcount);
      end
      tick();
      if (rs) begin
        foreach (free_at[r]) free_at[r] = 0;
        mcount = 0;
      end else if (!h) begin
        if (e_stall) mcount++;
        if (e_fire && we && d != 0 && lat != 0) free_at[d] = now + lat + 1;
        now++;
      end
    end
    i_rst = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_load_use();
    test_mul();
    test_wb_collision();
    test_waw_r0();
    test_hold();
    test_reset_sat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
